uart_rx_fsm: RTL and testbench

UART receiver that recovers frames produced by the transmit FSM: start bit, DATA_BITS data bits sent LSB first, optional parity bit, one stop bit. It sits at the far end of the serial line. It oversamples rx_serial on fast_baud_clk, which runs at OVERSAMPLE times the bit rate. It qualifies the start bit against glitches, samples each bit at mid-point, and presents each received word through a valid/ack holding register with error flags.

---
 rtl/uart_rx_fsm.sv | 117 +++++++++++
 tb/tb_uart_rx_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// UART receiver: 2-flop synchronizer, glitch-qualified start bit,
// mid-bit sampling, optional parity, valid/ack holding register with error flags.
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 fast_baud_clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic [1:0]           sync;
  logic                 rx_s;
  logic                 armed;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 sample;
  logic                 deliver;

  assign rx_s = sync[1];

  // State register
  always_ff @(posedge fast_baud_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (armed && !rx_s) state_next = START;
      START:  if (sample) state_next = rx_s ? IDLE : DATA;
      DATA:   if (sample && bit_idx == BW'(DATA_BITS - 1))
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (sample) state_next = STOP;
      STOP:   if (sample) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / strobe logic: sample point is mid start bit, then one bit period apart
  always_comb begin
    rx_busy = (state != IDLE);
    sample  = 1'b0;
    unique case (state)
      IDLE:    sample = 1'b0;
      START:   sample = (cnt == CW'(OVERSAMPLE / 2 - 1));
      default: sample = (cnt == CW'(OVERSAMPLE - 1));
    endcase
    deliver = (state == STOP) && sample;
  end

  // Synchronizer, counters, shift register, holding register and handshake
  always_ff @(posedge fast_baud_clk) begin
    if (reset) begin
      sync        <= '1;
      armed       <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      perr        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync  <= {sync[0], rx_serial};
      // armed only in IDLE with the line high; leaving IDLE requires rx_s = 0
      armed <= (state == IDLE) && rx_s;
      cnt   <= (state == IDLE || sample) ? '0 : cnt + CW'(1);

      if (state == START && sample) begin
        bit_idx <= '0;
        perr    <= 1'b0;
      end
      if (state == DATA && sample) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + BW'(1);
      end
      if (state == PARITY && sample)
        perr <= (^shift) ^ rx_s ^ (PARITY_ODD != 0);

      if (deliver) begin
        rx_data     <= shift;
        rx_valid    <= 1'b1;
        parity_err  <= (PARITY_EN != 0) ? perr : 1'b0;
        frame_err   <= !rx_s;
        overrun_err <= rx_valid && !rx_ack;
      end else if (rx_ack && rx_valid) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with default parameters.
module tb_uart_rx_fsm;

  localparam int OS = 16;
  localparam int NB = OS * 11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, rx_busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] s_data;
  logic       s_valid, s_perr, s_ferr, s_ovr, s_busy;
  logic       v170, v171;

  uart_rx_fsm #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .fast_baud_clk(clk),
    .reset(reset),
    .rx_serial(rx),
    .rx_ack(rx_ack),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame, one line bit per OS cycles, driven on negedges. Cycle i's values
  // are seen by the posedge right after negedge i; ack/reset pulse at given i.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int ack_at, input int rst_at, input int snap_at);
    for (int i = 0; i < NB; i++) begin
      int k;
      k = i / OS;
      if (k == 0)      rx = 1'b0;
      else if (k <= 8) rx = d[k-1];
      else if (k == 9) rx = par;
      else             rx = stp;
      rx_ack = (i == ack_at);
      reset  = (i == rst_at);
      if (i == snap_at) begin
        s_data = rx_data; s_valid = rx_valid; s_perr = parity_err;
        s_ferr = frame_err; s_ovr = overrun_err; s_busy = rx_busy;
      end
      if (i == 170) v170 = rx_valid;
      if (i == 171) v171 = rx_valid;
      @(negedge clk);
    end
    rx = 1'b1; rx_ack = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int deliveries;
    logic ferr_seen;

    // Reset state
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_perr", parity_err, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun_err, 0);
    check("reset_busy", rx_busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5, even parity bit 0, ack 5 cycles after rx_valid rises
    send_frame(8'hA5, 1'b0, 1'b1, 175, -1, 175);
    check("t1_valid_before_170", v170, 0);
    check("t1_valid_at_170", v171, 1);
    check("t1_valid_held", s_valid, 1);
    check("t1_data", s_data, 8'hA5);
    check("t1_perr", s_perr, 0);
    check("t1_ferr", s_ferr, 0);
    check("t1_ovr", s_ovr, 0);
    check("t1_valid_after_ack", rx_valid, 0);
    check("t1_busy_idle", rx_busy, 0);
    repeat (5) @(negedge clk);

    // 4-cycle glitch while idle
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("t2_busy_in_start", rx_busy, 1);
    repeat (30) @(negedge clk);
    check("t2_busy_back_idle", rx_busy, 0);
    check("t2_valid", rx_valid, 0);
    check("t2_perr", parity_err, 0);
    check("t2_ferr", frame_err, 0);

    // 0x3C with parity forced to 1
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1, 172);
    check("t3a_data", s_data, 8'h3C);
    check("t3a_perr", s_perr, 1);
    check("t3a_ferr", s_ferr, 0);
    rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0;
    repeat (5) @(negedge clk);

    // 0x3C with correct parity and stop bit low
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1, 172);
    check("t3b_data", s_data, 8'h3C);
    check("t3b_perr", s_perr, 0);
    check("t3b_ferr", s_ferr, 1);
    rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back 0x11 then 0x22, no ack
    send_frame(8'h11, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'h22, 1'b0, 1'b1, -1, -1, 172);
    check("t4a_valid", s_valid, 1);
    check("t4a_data", s_data, 8'h22);
    check("t4a_ovr", s_ovr, 1);
    check("t4a_ferr", s_ferr, 0);
    rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0;
    check("t4a_ovr_cleared", overrun_err, 0);
    repeat (5) @(negedge clk);

    // Back-to-back again, ack in the same cycle as the second delivery
    send_frame(8'h11, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'h22, 1'b0, 1'b1, 170, -1, 172);
    check("t4b_valid", s_valid, 1);
    check("t4b_data", s_data, 8'h22);
    check("t4b_ovr", s_ovr, 0);
    rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0;
    repeat (5) @(negedge clk);

    // Break: 30 bit times low, ack every delivery as soon as it is seen
    deliveries = 0;
    ferr_seen = 1'b0;
    for (int i = 0; i < 30 * OS; i++) begin
      rx = 1'b0;
      rx_ack = rx_valid;
      if (rx_valid) begin
        deliveries++;
        ferr_seen = frame_err;
      end
      @(negedge clk);
    end
    rx_ack = 1'b0;
    check("t5_break_deliveries", deliveries, 1);
    check("t5_break_ferr", ferr_seen, 1);
    check("t5_break_no_retrigger", rx_busy, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_idle_after_break", rx_valid, 0);
    send_frame(8'h55, 1'b0, 1'b1, -1, -1, 172);
    check("t5_data", s_data, 8'h55);
    check("t5_perr", s_perr, 0);
    check("t5_ferr", s_ferr, 0);
    check("t5_ovr", s_ovr, 0);
    // 0x55 is left unacked so the reset below has a held word to clear

    repeat (5) @(negedge clk);
    // Reset during data bit 4 (cycles 80..95); line stays high after bit 4
    send_frame(8'hFF, 1'b1, 1'b1, -1, 88, 89);
    check("t6_rst_valid", s_valid, 0);
    check("t6_rst_data", s_data, 0);
    check("t6_rst_busy", s_busy, 0);
    check("t6_rst_ferr", s_ferr, 0);
    check("t6_rst_ovr", s_ovr, 0);
    check("t6_no_delivery", rx_valid, 0);
    check("t6_idle", rx_busy, 0);
    repeat (5) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1, -1, -1, 172);
    check("t6_valid", s_valid, 1);
    check("t6_data", s_data, 8'h81);
    check("t6_perr", s_perr, 0);
    check("t6_ferr", s_ferr, 0);
    check("t6_ovr", s_ovr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
